// File: rtl/cp0_pkg.sv
// cp0_pkg: shared CP0 register addresses, exception codes and FSM state encoding
package cp0_pkg;
   localparam logic [4:0] ADDR_STATUS = 5'd12;
   localparam logic [4:0] ADDR_CAUSE  = 5'd13;
   localparam logic [4:0] ADDR_EPC    = 5'd14;
   localparam logic [4:0] ADDR_EXCCNT = 5'd22;
   localparam logic [4:0] EXC_RI      = 5'd10;
   localparam logic [4:0] EXC_OV      = 5'd12;
   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_FLUSH    = 2'd1,
      ST_REDIRECT = 2'd2
   } state_t;
endpackage

// File: rtl/cp0_regfile.sv
// cp0_regfile: STATUS/CAUSE/EPC/EXCCNT storage with exception > eret > mtc0 write priority
module cp0_regfile
   import cp0_pkg::*;
#(
   parameter int                 DATA_W       = 32,
   parameter int                 CNT_W        = 16,
   parameter logic [DATA_W-1:0]  RESET_STATUS = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_exc,
   input  logic [4:0]        i_exc_code,
   input  logic [DATA_W-1:0] i_exc_epc,
   input  logic              i_eret,
   input  logic              i_we,
   input  logic [4:0]        i_addr,
   input  logic [DATA_W-1:0] i_wdata,
   output logic [DATA_W-1:0] o_rdata,
   output logic [DATA_W-1:0] o_epc,
   output logic              o_exl
);
   logic [1:0]        r_status;
   logic [4:0]        r_exccode;
   logic [DATA_W-1:0] r_epc;
   logic [CNT_W-1:0]  r_cnt;
   logic              w_unused;

   assign w_unused = ^RESET_STATUS[DATA_W-1:2];
   assign o_epc    = r_epc;
   assign o_exl    = r_status[1];

   // register updates; the caller guarantees at most one of exc/eret/we is set
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_status  <= RESET_STATUS[1:0];
         r_exccode <= '0;
         r_epc     <= '0;
         r_cnt     <= '0;
      end else if (i_exc) begin
         r_exccode   <= i_exc_code;
         if (!r_status[1]) r_epc <= i_exc_epc;
         r_status[1] <= 1'b1;
         r_cnt       <= r_cnt + CNT_W'(~&r_cnt);
      end else if (i_eret) begin
         r_status[1] <= 1'b0;
      end else if (i_we) begin
         if (i_addr == ADDR_STATUS) r_status  <= i_wdata[1:0];
         if (i_addr == ADDR_CAUSE)  r_exccode <= i_wdata[6:2];
         if (i_addr == ADDR_EPC)    r_epc     <= i_wdata;
      end
   end

   // MFC0 read mux from registered state only
   always_comb begin
      o_rdata = (i_addr == ADDR_STATUS) ? {{(DATA_W-2){1'b0}}, r_status} :
                (i_addr == ADDR_CAUSE)  ? {{(DATA_W-7){1'b0}}, r_exccode, 2'b00} :
                (i_addr == ADDR_EPC)    ? r_epc :
                (i_addr == ADDR_EXCCNT) ? DATA_W'(r_cnt) : '0;
   end
endmodule

// File: rtl/cp0_exc_ctrl.sv
// cp0_exc_ctrl: exception/ERET sequencer driving pipeline flush and fetch redirect
module cp0_exc_ctrl
   import cp0_pkg::*;
#(
   parameter int                 DATA_W       = 32,
   parameter int                 CNT_W        = 16,
   parameter logic [DATA_W-1:0]  RESET_STATUS = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_exc_req,
   input  logic [DATA_W-1:0] i_exc_cause,
   input  logic [DATA_W-1:0] i_exc_epc,
   input  logic [DATA_W-1:0] i_exc_vec,
   input  logic              i_eret,
   input  logic              i_mtc0_we,
   input  logic [4:0]        i_c0_addr,
   input  logic [DATA_W-1:0] i_c0_wdata,
   output logic [DATA_W-1:0] o_c0_rdata,
   output logic              o_flush,
   output logic              o_redirect_valid,
   input  logic              i_redirect_ready,
   output logic [DATA_W-1:0] o_redirect_pc,
   output logic              o_exl
);
   state_t            r_state;
   logic              r_flush;
   logic              r_valid;
   logic [DATA_W-1:0] r_pc;
   logic [DATA_W-1:0] w_epc;
   logic              w_idle;
   logic              w_unused;

   assign w_idle           = (r_state == ST_IDLE);
   assign w_unused         = ^i_exc_cause[DATA_W-1:5];
   assign o_flush          = r_flush;
   assign o_redirect_valid = r_valid;
   assign o_redirect_pc    = r_pc;

   cp0_regfile #(
      .DATA_W       (DATA_W),
      .CNT_W        (CNT_W),
      .RESET_STATUS (RESET_STATUS)
   ) u_regfile (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_exc      (w_idle && i_exc_req),
      .i_exc_code (i_exc_cause[4:0]),
      .i_exc_epc  (i_exc_epc),
      .i_eret     (w_idle && i_eret && !i_exc_req),
      .i_we       (w_idle && i_mtc0_we && !i_exc_req && !i_eret),
      .i_addr     (i_c0_addr),
      .i_wdata    (i_c0_wdata),
      .o_rdata    (o_c0_rdata),
      .o_epc      (w_epc),
      .o_exl      (o_exl)
   );

   // IDLE -> FLUSH -> REDIRECT (held until accepted) -> IDLE; target latched on entry
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_flush <= 1'b0;
         r_valid <= 1'b0;
         r_pc    <= '0;
      end else begin
         case (r_state)
            ST_IDLE: if (i_exc_req || i_eret) begin
               r_pc    <= i_exc_req ? i_exc_vec : w_epc;
               r_flush <= 1'b1;
               r_state <= ST_FLUSH;
            end
            ST_FLUSH: begin
               r_valid <= 1'b1;
               r_state <= ST_REDIRECT;
            end
            ST_REDIRECT: if (i_redirect_ready) begin
               r_valid <= 1'b0;
               r_flush <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// tb_cp0_exc_ctrl: directed and randomized checks of cp0_exc_ctrl against a behavioural model
module tb_cp0_exc_ctrl;
   import cp0_pkg::*;
   localparam int DW = 32;
   localparam int CW = 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          exc_req = 1'b0, eret = 1'b0, mtc0_we = 1'b0, ready = 1'b1;
   logic [DW-1:0] cause = '0, epc_in = '0, vec = '0, wdata = '0;
   logic [4:0]    addr = '0;
   logic [DW-1:0] rdata, rpc;
   logic          flush, rvalid, exl;

   int n_chk = 0;
   int n_fail = 0;

   // behavioural model: architectural registers plus a phase counter (0 idle, 1 flush, 2 redirect)
   logic [1:0]    m_st;
   logic [4:0]    m_code;
   logic [DW-1:0] m_epc, m_target;
   int            m_cnt, m_phase;

   cp0_exc_ctrl #(.DATA_W(DW), .CNT_W(CW), .RESET_STATUS('0)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .i_exc_req        (exc_req),
      .i_exc_cause      (cause),
      .i_exc_epc        (epc_in),
      .i_exc_vec        (vec),
      .i_eret           (eret),
      .i_mtc0_we        (mtc0_we),
      .i_c0_addr        (addr),
      .i_c0_wdata       (wdata),
      .o_c0_rdata       (rdata),
      .o_flush          (flush),
      .o_redirect_valid (rvalid),
      .i_redirect_ready (ready),
      .o_redirect_pc    (rpc),
      .o_exl            (exl)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] m_read(input logic [4:0] a);
      if (a == ADDR_STATUS) return DW'(m_st);
      if (a == ADDR_CAUSE)  return DW'(m_code) << 2;
      if (a == ADDR_EPC)    return m_epc;
      if (a == ADDR_EXCCNT) return DW'(m_cnt);
      return '0;
   endfunction

   task automatic m_reset();
      m_st = 2'b00; m_code = '0; m_epc = '0; m_target = '0; m_cnt = 0; m_phase = 0;
   endtask

   task automatic check_all(input string tag);
      chk({tag, "_flush"}, DW'(flush), DW'(m_phase != 0));
      chk({tag, "_valid"}, DW'(rvalid), DW'(m_phase == 2));
      chk({tag, "_pc"}, rpc, m_target);
      chk({tag, "_exl"}, DW'(exl), DW'(m_st[1]));
      chk({tag, "_rdata"}, rdata, m_read(addr));
   endtask

   // advance one clock: model consumes the inputs sampled at the edge, then everything is compared
   task automatic step(input string tag);
      if (m_phase == 0) begin
         if (exc_req) begin
            m_code = cause[4:0];
            if (!m_st[1]) m_epc = epc_in;
            m_st[1] = 1'b1;
            m_cnt = (m_cnt == (1 << CW) - 1) ? m_cnt : m_cnt + 1;
            m_target = vec;
            m_phase = 1;
         end else if (eret) begin
            m_st[1] = 1'b0;
            m_target = m_epc;
            m_phase = 1;
         end else if (mtc0_we) begin
            if (addr == ADDR_STATUS) m_st = wdata[1:0];
            if (addr == ADDR_CAUSE) m_code = wdata[6:2];
            if (addr == ADDR_EPC) m_epc = wdata;
         end
      end else if (m_phase == 1) m_phase = 2;
      else if (ready) m_phase = 0;
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   task automatic idle_inputs();
      exc_req = 1'b0; eret = 1'b0; mtc0_we = 1'b0; ready = 1'b1;
   endtask

   // asynchronous reset mid-cycle; outputs must drop before any clock edge
   task automatic async_reset(input string tag);
      #2 rst_n = 1'b0;
      #1;
      m_reset();
      check_all(tag);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic run_to_idle(input string tag);
      idle_inputs();
      for (int i = 0; i < 3; i++) step(tag);
   endtask

   initial begin
      m_reset();
      #1;
      check_all("rst");
      @(negedge clk);
      rst_n = 1'b1;
      addr = ADDR_STATUS;
      step("rst_idle");

      // overflow exception
      exc_req = 1'b1; cause = DW'(EXC_OV); epc_in = 32'h0040_0010; vec = 32'h8000_0018; addr = ADDR_CAUSE;
      step("t1_take");
      chk("t1_cause", rdata, 32'h30);
      idle_inputs(); addr = ADDR_EPC;
      step("t1_flush");
      chk("t1_epc", rdata, 32'h0040_0010);
      addr = ADDR_EXCCNT;
      step("t1_redir");
      chk("t1_pc", rpc, 32'h8000_0018);
      chk("t1_cnt", rdata, 32'd1);
      step("t1_done");

      // ERET back to the faulting address
      eret = 1'b1; addr = ADDR_STATUS;
      step("t2_eret");
      chk("t2_status", rdata, 32'h0);
      run_to_idle("t2_run");
      chk("t2_pc", rpc, 32'h0040_0010);

      // exception beats eret and mtc0 in the same cycle
      exc_req = 1'b1; eret = 1'b1; mtc0_we = 1'b1; cause = DW'(EXC_RI); epc_in = 32'h0000_2000;
      vec = 32'h8000_0000; addr = ADDR_EPC; wdata = 32'hDEAD_BEEF;
      step("t3_take");
      chk("t3_epc", rdata, 32'h0000_2000);
      run_to_idle("t3_run");
      chk("t3_pc", rpc, 32'h8000_0000);

      // nested exception keeps EPC, updates CAUSE; hold redirect for 5 cycles
      exc_req = 1'b1; cause = DW'(EXC_OV); epc_in = 32'h0000_0100; vec = 32'h8000_0180; addr = ADDR_EPC;
      step("t4_take");
      chk("t4_epc", rdata, 32'h0000_2000);
      idle_inputs(); ready = 1'b0;
      step("t4_flush");
      for (int i = 0; i < 5; i++) begin
         exc_req = i[0]; eret = ~i[0]; vec = $urandom;
         step("t5_hold");
      end
      idle_inputs();
      step("t5_xfer");
      chk("t5_idle_valid", DW'(rvalid), 32'd0);

      // mtc0 with eret: eret wins, write dropped
      eret = 1'b1; mtc0_we = 1'b1; addr = ADDR_EPC; wdata = 32'h1234_5678;
      step("t_mtc0_eret");
      run_to_idle("t_mtc0_eret_run");
      chk("t_mtc0_eret_pc", rpc, 32'h0000_2000);

      // counter saturation at 2^CW-1
      for (int k = 0; k < 4; k++) begin
         exc_req = 1'b1; cause = $urandom; vec = $urandom; epc_in = $urandom; addr = ADDR_EXCCNT;
         step("t6_sat_take");
         run_to_idle("t6_sat_run");
      end
      chk("t6_sat", rdata, 32'd3);

      // reset while redirect is pending
      exc_req = 1'b1; vec = 32'h8000_0200; ready = 1'b0;
      step("t6_take");
      exc_req = 1'b0;
      step("t6_flush");
      step("t6_redir");
      async_reset("t6_rst");
      chk("t6_rst_valid", DW'(rvalid), 32'd0);

      // randomized traffic
      for (int n = 0; n < 2000; n++) begin
         exc_req = ($urandom_range(0, 5) == 0);
         eret    = ($urandom_range(0, 4) == 0);
         mtc0_we = ($urandom_range(0, 1) == 0);
         ready   = ($urandom_range(0, 2) != 0);
         cause   = $urandom;
         epc_in  = $urandom;
         vec     = $urandom;
         wdata   = $urandom;
         case ($urandom_range(0, 4))
            0: addr = ADDR_STATUS;
            1: addr = ADDR_CAUSE;
            2: addr = ADDR_EPC;
            3: addr = ADDR_EXCCNT;
            default: addr = 5'($urandom);
         endcase
         if ($urandom_range(0, 299) == 0) async_reset("rnd_rst");
         else step("rnd");
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
